// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Central command scheduler for the SDRAM controller. While the init
// sequencer runs it owns the SDRAM pins; after init_end it arbitrates
// between auto-refresh, write-burst and read-burst sub-blocks. It also
// owns the periodic refresh timer.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   init_end_i/init_cmd_i/addr_i   init sequencer status and bus request
//   aref_en_o/aref_end_i/...       refresh sub-block handshake and bus
//   ref_req_o                      refresh pending (sub-blocks may cut bursts)
//   wr_req_i/wr_en_o/wr_end_i/...  write sub-block handshake and bus
//   rd_req_i/rd_en_o/rd_end_i/...  read sub-block handshake and bus
//   sdram_cmd_o/addr_o/bank_o      SDRAM command, address and bank pins
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int REF_PERIOD = 780
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end_i,
  input  logic [3:0]            init_cmd_i,
  input  logic [ADDR_WIDTH-1:0] init_addr_i,
  output logic                  aref_en_o,
  input  logic                  aref_end_i,
  input  logic [3:0]            aref_cmd_i,
  input  logic [ADDR_WIDTH-1:0] aref_addr_i,
  output logic                  ref_req_o,
  input  logic                  wr_req_i,
  output logic                  wr_en_o,
  input  logic                  wr_end_i,
  input  logic [3:0]            wr_cmd_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [1:0]            wr_bank_i,
  input  logic                  rd_req_i,
  output logic                  rd_en_o,
  input  logic                  rd_end_i,
  input  logic [3:0]            rd_cmd_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [1:0]            rd_bank_i,
  output logic [3:0]            sdram_cmd_o,
  output logic [ADDR_WIDTH-1:0] sdram_addr_o,
  output logic [1:0]            sdram_bank_o
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam int         CNT_W   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_e;

  typedef enum logic {
    GRANT_WRITE,
    GRANT_READ
  } grant_e;

  state_e           state_q, state_d;
  grant_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_req_q, ref_req_d;
  logic             ref_wrap;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      last_grant_q <= GRANT_READ;
      ref_cnt_q    <= '0;
      ref_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_req_q    <= ref_req_d;
    end
  end

  // Refresh timer: frozen at 0 until init completes, then free-running.
  // A wrap sets the request; it takes priority over a same-edge clear so
  // a refresh period is never lost.
  assign ref_wrap = init_end_i && (ref_cnt_q == CNT_LAST);

  always_comb begin
    ref_cnt_d = ref_cnt_q + CNT_W'(1);
    ref_req_d = ref_req_q;
    if (!init_end_i) begin
      ref_cnt_d = '0;
      ref_req_d = 1'b0;
    end else if (ref_wrap) begin
      ref_cnt_d = '0;
      ref_req_d = 1'b1;
    end else if (state_q == S_AREF && aref_end_i) begin
      ref_req_d = 1'b0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (!init_end_i) begin
      state_d = S_INIT;
    end else begin
      unique case (state_q)
        S_INIT:  state_d = S_ARBIT;
        S_ARBIT: begin
          // Refresh first; with both bursts pending, alternate.
          if (ref_req_q) begin
            state_d = S_AREF;
          end else if (wr_req_i && (!rd_req_i || last_grant_q == GRANT_READ)) begin
            state_d      = S_WRITE;
            last_grant_d = GRANT_WRITE;
          end else if (rd_req_i) begin
            state_d      = S_READ;
            last_grant_d = GRANT_READ;
          end
        end
        S_AREF:  if (aref_end_i) state_d = S_ARBIT;
        S_WRITE: if (wr_end_i)   state_d = S_ARBIT;
        S_READ:  if (rd_end_i)   state_d = S_ARBIT;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Bus mux and grants follow the registered state only.
  always_comb begin
    sdram_cmd_o  = CMD_NOP;
    sdram_addr_o = '0;
    sdram_bank_o = 2'b00;
    aref_en_o    = 1'b0;
    wr_en_o      = 1'b0;
    rd_en_o      = 1'b0;
    unique case (state_q)
      S_INIT: begin
        sdram_cmd_o  = init_cmd_i;
        sdram_addr_o = init_addr_i;
      end
      S_AREF: begin
        aref_en_o    = 1'b1;
        sdram_cmd_o  = aref_cmd_i;
        sdram_addr_o = aref_addr_i;
      end
      S_WRITE: begin
        wr_en_o      = 1'b1;
        sdram_cmd_o  = wr_cmd_i;
        sdram_addr_o = wr_addr_i;
        sdram_bank_o = wr_bank_i;
      end
      S_READ: begin
        rd_en_o      = 1'b1;
        sdram_cmd_o  = rd_cmd_i;
        sdram_addr_o = rd_addr_i;
        sdram_bank_o = rd_bank_i;
      end
      default: ;
    endcase
  end

  assign ref_req_o = ref_req_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter: a directed vector table for the
// init hand-off, burst grants and round-robin, hand-written sequences for
// the refresh timer corners and reset, and a randomized phase compared
// cycle by cycle against a bus-ownership model.
module tb_sdram_arbiter;

  localparam int         AW     = 12;
  localparam int         PERIOD = 780;
  localparam logic [3:0] NOP    = 4'b0111;

  logic          clk;
  logic          rst_n;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          aref_en, aref_end;
  logic [3:0]    aref_cmd;
  logic [AW-1:0] aref_addr;
  logic          ref_req;
  logic          wr_req, wr_en, wr_end;
  logic [3:0]    wr_cmd;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_bank;
  logic          rd_req, rd_en, rd_end;
  logic [3:0]    rd_cmd;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_bank;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [1:0]    sdram_bank;

  sdram_arbiter #(.ADDR_WIDTH(AW), .REF_PERIOD(PERIOD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_end_i  (init_end),
    .init_cmd_i  (init_cmd),
    .init_addr_i (init_addr),
    .aref_en_o   (aref_en),
    .aref_end_i  (aref_end),
    .aref_cmd_i  (aref_cmd),
    .aref_addr_i (aref_addr),
    .ref_req_o   (ref_req),
    .wr_req_i    (wr_req),
    .wr_en_o     (wr_en),
    .wr_end_i    (wr_end),
    .wr_cmd_i    (wr_cmd),
    .wr_addr_i   (wr_addr),
    .wr_bank_i   (wr_bank),
    .rd_req_i    (rd_req),
    .rd_en_o     (rd_en),
    .rd_end_i    (rd_end),
    .rd_cmd_i    (rd_cmd),
    .rd_addr_i   (rd_addr),
    .rd_bank_i   (rd_bank),
    .sdram_cmd_o (sdram_cmd),
    .sdram_addr_o(sdram_addr),
    .sdram_bank_o(sdram_bank)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: who owns the bus, whether init is still in charge,
  // how many clocks the refresh period has run, and whether a refresh is
  // owed. Advanced once per rising edge from the inputs seen at that edge.
  // ---------------------------------------------------------------------
  localparam int IDLE = 0, REFRESH = 1, WRITER = 2, READER = 3;

  typedef struct {
    bit booting;
    int owner;
    int ticks;
    bit pending;
    bit last_read;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur);
    model_t n;
    bit     wrap;
    bit     done;
    n = cur;
    if (!rst_n) begin
      n.booting   = 1'b1;
      n.owner     = IDLE;
      n.ticks     = 0;
      n.pending   = 1'b0;
      n.last_read = 1'b1;
    end else if (!init_end) begin
      n.booting = 1'b1;
      n.owner   = IDLE;
      n.ticks   = 0;
      n.pending = 1'b0;
    end else begin
      wrap    = (cur.ticks == PERIOD - 1);
      n.ticks = (cur.ticks + 1) % PERIOD;
      if (wrap) n.pending = 1'b1;
      else if (!cur.booting && cur.owner == REFRESH && aref_end) n.pending = 1'b0;
      if (cur.booting) begin
        n.booting = 1'b0;
        n.owner   = IDLE;
      end else if (cur.owner == IDLE) begin
        if (cur.pending)            n.owner = REFRESH;
        else if (wr_req && rd_req)  n.owner = cur.last_read ? WRITER : READER;
        else if (wr_req)            n.owner = WRITER;
        else if (rd_req)            n.owner = READER;
        if (n.owner == WRITER) n.last_read = 1'b0;
        if (n.owner == READER) n.last_read = 1'b1;
      end else begin
        done = (cur.owner == REFRESH && aref_end) ||
               (cur.owner == WRITER  && wr_end)   ||
               (cur.owner == READER  && rd_end);
        if (done) n.owner = IDLE;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  task automatic compare_model();
    logic [3:0]    c;
    logic [AW-1:0] a;
    logic [1:0]    b;
    logic [2:0]    en;
    c = NOP; a = '0; b = 2'b00; en = 3'b000;
    if (m.booting) begin
      c = init_cmd; a = init_addr;
    end else if (m.owner == REFRESH) begin
      c = aref_cmd; a = aref_addr; en = 3'b100;
    end else if (m.owner == WRITER) begin
      c = wr_cmd; a = wr_addr; b = wr_bank; en = 3'b010;
    end else if (m.owner == READER) begin
      c = rd_cmd; a = rd_addr; b = rd_bank; en = 3'b001;
    end
    check("rnd_cmd",     32'(sdram_cmd),  32'(c));
    check("rnd_addr",    32'(sdram_addr), 32'(a));
    check("rnd_bank",    32'(sdram_bank), 32'(b));
    check("rnd_en",      32'({aref_en, wr_en, rd_en}), 32'(en));
    check("rnd_ref_req", 32'(ref_req),    32'(m.pending));
  endtask

  // From one falling edge to the next, passing exactly one rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fixed_buses();
    init_cmd = 4'b0010; init_addr = 12'h111;
    aref_cmd = 4'b0001; aref_addr = 12'h400;
    wr_cmd   = 4'b0100; wr_addr   = 12'h222; wr_bank = 2'b10;
    rd_cmd   = 4'b0101; rd_addr   = 12'h333; rd_bank = 2'b01;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; init_end = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_end = 1'b0; rd_end = 1'b0; aref_end = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          ie, w, r, we, re;
    logic [2:0]    en;    // {aref_en, wr_en, rd_en}
    logic [3:0]    cmd;
    logic [AW-1:0] addr;
    logic [1:0]    bank;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    vec_t v;

    set_fixed_buses();
    @(negedge clk);
    do_reset();

    // --- table: init hand-off, 4-beat write, round-robin, stray ends ---
    //                 ie    w     r     we    re    en      cmd      addr    bank
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0010, 12'h111, 2'b00}); // INIT
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0010, 12'h111, 2'b00}); // INIT, leaving
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00}); // idle
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00}); // both -> W
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0100, 12'h222, 2'b10});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 4'b0100, 12'h222, 2'b10}); // rd_end ignored
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0100, 12'h222, 2'b10});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 4'b0100, 12'h222, 2'b10}); // wr_end
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00}); // gap -> R
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 4'b0101, 12'h333, 2'b01});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 4'b0101, 12'h333, 2'b01}); // wr_end ignored
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 4'b0101, 12'h333, 2'b01}); // rd_end
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00}); // gap -> W
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0100, 12'h222, 2'b10});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0100, 12'h222, 2'b10});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 4'b0100, 12'h222, 2'b10});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00}); // gap -> R
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 4'b0101, 12'h333, 2'b01});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 4'b0101, 12'h333, 2'b01});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 4'b0101, 12'h333, 2'b01});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, NOP,     12'h000, 2'b00}); // ends ignored
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00}); // rd only -> R
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4'b0101, 12'h333, 2'b01});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 4'b0101, 12'h333, 2'b01});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, NOP,     12'h000, 2'b00});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      init_end = v.ie; wr_req = v.w; rd_req = v.r; wr_end = v.we; rd_end = v.re;
      #1;
      check($sformatf("vec%0d_en", i),      32'({aref_en, wr_en, rd_en}), 32'(v.en));
      check($sformatf("vec%0d_cmd", i),     32'(sdram_cmd),  32'(v.cmd));
      check($sformatf("vec%0d_addr", i),    32'(sdram_addr), 32'(v.addr));
      check($sformatf("vec%0d_bank", i),    32'(sdram_bank), 32'(v.bank));
      check($sformatf("vec%0d_ref_req", i), 32'(ref_req),    32'(0));
      step();
    end

    // --- refresh timer: exact period, then set/clear on the same edge ---
    do_reset();
    init_end = 1'b1;
    for (int i = 0; i < PERIOD - 1; i++) step();
    #1 check("ref_before_period", 32'(ref_req), 32'(0));
    step();
    #1 check("ref_at_period", 32'(ref_req), 32'(1));
    check("aref_en_not_yet", 32'(aref_en), 32'(0));
    step();                                         // 781 edges
    #1 check("aref_en_granted", 32'(aref_en), 32'(1));
    check("aref_cmd", 32'(sdram_cmd),  32'(4'b0001));
    check("aref_addr", 32'(sdram_addr), 32'(12'h400));
    check("aref_bank", 32'(sdram_bank), 32'(0));
    for (int i = 0; i < PERIOD - 2; i++) step();    // 1559 edges, AREF held
    #1 check("aref_still_held", 32'(aref_en), 32'(1));
    aref_end = 1'b1;                                // lands on the 2nd wrap
    step();
    aref_end = 1'b0;
    #1 check("ref_set_wins", 32'(ref_req), 32'(1));
    check("aref_released", 32'(aref_en), 32'(0));
    check("gap_nop", 32'(sdram_cmd), 32'(NOP));
    step();
    #1 check("aref_regrant", 32'(aref_en), 32'(1));
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    #1 check("ref_cleared", 32'(ref_req), 32'(0));
    check("aref_done", 32'(aref_en), 32'(0));

    // --- refresh request mid-write: no preemption, AREF beats read ---
    do_reset();
    init_end = 1'b1; wr_req = 1'b1;
    step();
    step();                                         // 2 edges
    #1 check("mid_wr_granted", 32'(wr_en), 32'(1));
    wr_req = 1'b0;
    for (int i = 0; i < PERIOD - 2; i++) step();    // 780 edges
    #1 check("mid_wr_ref_req", 32'(ref_req), 32'(1));
    check("mid_wr_kept", 32'(wr_en), 32'(1));
    check("mid_wr_cmd", 32'(sdram_cmd), 32'(4'b0100));
    step();
    step();
    #1 check("mid_wr_still", 32'(wr_en), 32'(1));
    rd_req = 1'b1; wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    #1 check("post_wr_gap", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    check("post_wr_nop", 32'(sdram_cmd), 32'(NOP));
    step();
    #1 check("aref_over_read", 32'({aref_en, wr_en, rd_en}), 32'(3'b100));
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    #1 check("ref_cleared2", 32'(ref_req), 32'(0));
    step();
    #1 check("read_after_ref", 32'({aref_en, wr_en, rd_en}), 32'(3'b001));

    // --- one-edge reset in the middle of a read ---
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rd_req = 1'b0;
    #1 check("rst_rd_en", 32'(rd_en), 32'(0));
    check("rst_init_cmd", 32'(sdram_cmd),  32'(4'b0010));
    check("rst_init_addr", 32'(sdram_addr), 32'(12'h111));
    check("rst_ref_req", 32'(ref_req), 32'(0));
    n = 0;
    while (!ref_req && n < 1000) begin
      step();
      n++;
      #1;
    end
    check("rst_timer_restart", 32'(n), 32'(PERIOD));

    // --- randomized traffic against the model ---
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 1000; c++) begin
        rst_n     = !(blk == 3 && c == 0);
        init_end  = (c >= 3) && ($urandom_range(0, 1499) != 0);
        wr_req    = ($urandom_range(0, 2) != 0);
        rd_req    = ($urandom_range(0, 2) != 0);
        wr_end    = ($urandom_range(0, 3) == 0);
        rd_end    = ($urandom_range(0, 3) == 0);
        aref_end  = ($urandom_range(0, 3) == 0);
        init_cmd  = 4'($urandom);  init_addr = AW'($urandom);
        aref_cmd  = 4'($urandom);  aref_addr = AW'($urandom);
        wr_cmd    = 4'($urandom);  wr_addr   = AW'($urandom); wr_bank = 2'($urandom);
        rd_cmd    = 4'($urandom);  rd_addr   = AW'($urandom); rd_bank = 2'($urandom);
        #1 compare_model();
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
